// File: rtl/axi_slave_ram_model.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_model
// AXI4 slave memory model (no IDs, one outstanding burst per direction).
// Supports FIXED / INCR / WRAP bursts, byte strobes, a programmable read
// latency, SLVERR for beats whose word index is beyond C_DEPTH, and a
// full-word preload port that works in every state, including reset.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   AW*  (ADDR/LEN/BURST)    write burst request, AWVALID/AWREADY handshake
//   W*   (DATA/STRB/LAST)    write beats, WVALID/WREADY handshake (WLAST unused;
//                            the beat counter decides where a burst ends)
//   B*   (RESP)              write response, BVALID/BREADY handshake
//   AR*  (ADDR/LEN/BURST)    read burst request, ARVALID/ARREADY handshake
//   R*   (DATA/RESP/LAST)    read beats, RVALID/RREADY handshake
//   PL_* (WE/ADDR/WDATA)     preload, word-indexed, wins over an AXI write
// ---------------------------------------------------------------------------
module axi_slave_ram_model #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_DEPTH          = 2048,
  parameter int C_RD_LATENCY     = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [C_OFFSET_WIDTH-1:0]       AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_OFFSET_WIDTH-1:0]       ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY,
  input  logic                            PL_WE,
  input  logic [$clog2(C_DEPTH)-1:0]      PL_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]     PL_WDATA
);

  localparam int BPW = C_AXI_DATA_WIDTH / 8;
  localparam int BSH = $clog2(BPW);
  localparam int IW  = $clog2(C_DEPTH);
  localparam logic [C_OFFSET_WIDTH-1:0] DEPTH_A  = C_OFFSET_WIDTH'(C_DEPTH);
  localparam logic [C_OFFSET_WIDTH-1:0] BPW_A    = C_OFFSET_WIDTH'(BPW);
  localparam logic [C_OFFSET_WIDTH-1:0] LOWMASK  = C_OFFSET_WIDTH'(BPW - 1);
  localparam logic [3:0]                LAT_LAST = 4'(C_RD_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_e;

  // Word index is the byte address with the in-word offset dropped.
  function automatic logic in_range(input logic [C_OFFSET_WIDTH-1:0] a);
    return (a >> BSH) < DEPTH_A;
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [C_OFFSET_WIDTH-1:0] a);
    logic [C_OFFSET_WIDTH-1:0] w;
    w = a >> BSH;
    return w[IW-1:0];
  endfunction

  // WRAP boundary mask is (len+1)*BPW-1, only meaningful for len+1 = 2/4/8/16.
  function automatic logic [C_OFFSET_WIDTH-1:0] next_addr(
    input logic [C_OFFSET_WIDTH-1:0] a, input logic [7:0] len, input logic [1:0] burst);
    logic [C_OFFSET_WIDTH-1:0] inc, mask;
    inc  = a + BPW_A;
    mask = (C_OFFSET_WIDTH'(len) << BSH) | LOWMASK;
    case (burst)
      2'd0:    return a;
      2'd2:    begin
                 if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                   return (a & ~mask) | (inc & mask);
                 else
                   return inc;
               end
      default: return inc;
    endcase
  endfunction

  logic [C_AXI_DATA_WIDTH-1:0] mem_q [C_DEPTH];

  wstate_e                     wstate_q;
  logic [C_OFFSET_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]                  wlen_q, wcnt_q;
  logic [1:0]                  wburst_q, bresp_q;
  logic                        werr_q, awready_q, wready_q, bvalid_q;
  logic                        wbeat_s, w_ok_s;

  rstate_e                     rstate_q;
  logic [C_OFFSET_WIDTH-1:0]   raddr_q, raddr_d, rd_src_s;
  logic [7:0]                  rlen_q, rcnt_q;
  logic [1:0]                  rburst_q, rresp_q;
  logic [3:0]                  wait_q;
  logic                        arready_q, rvalid_q, rlast_q, rd_ok_s;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rd_word_s;

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

  assign waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
  assign raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
  // A beat presented during reset must not touch memory (burst is aborted).
  assign wbeat_s = wready_q & WVALID & ~RST;
  assign w_ok_s  = in_range(waddr_q);

  // Address whose word is loaded into RDATA at the coming edge.
  always_comb begin
    rd_src_s = raddr_q;
    case (rstate_q)
      R_IDLE:  rd_src_s = ARADDR;
      R_WAIT:  rd_src_s = raddr_q;
      R_DATA:  rd_src_s = raddr_d;
      default: rd_src_s = raddr_q;
    endcase
  end

  assign rd_ok_s   = in_range(rd_src_s);
  assign rd_word_s = rd_ok_s ? mem_q[idx_of(rd_src_s)] : '0;

  // Memory array: strobed AXI write, then preload (later assignment wins).
  always_ff @(posedge CLK) begin
    if (wbeat_s && w_ok_s) begin
      for (int j = 0; j < BPW; j++) begin
        if (WSTRB[j]) mem_q[idx_of(waddr_q)][8*j +: 8] <= WDATA[8*j +: 8];
      end
    end
    if (PL_WE) mem_q[PL_ADDR] <= PL_WDATA;
  end

  // Write channel FSM with registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      wburst_q  <= 2'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (AWVALID && awready_q) begin
            waddr_q   <= AWADDR;
            wlen_q    <= AWLEN;
            wburst_q  <= AWBURST;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            if (!w_ok_s) werr_q <= 1'b1;
            if (wcnt_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || !w_ok_s) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end else begin
              wcnt_q  <= wcnt_q + 8'd1;
              waddr_q <= waddr_d;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; RDATA/RRESP/RLAST only change on a load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      rburst_q  <= 2'd0;
      wait_q    <= 4'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ARVALID && arready_q) begin
            raddr_q   <= ARADDR;
            rlen_q    <= ARLEN;
            rburst_q  <= ARBURST;
            rcnt_q    <= 8'd0;
            wait_q    <= 4'd0;
            arready_q <= 1'b0;
            if (C_RD_LATENCY == 0) begin
              rvalid_q <= 1'b1;
              rdata_q  <= rd_word_s;
              rresp_q  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
              rlast_q  <= (ARLEN == 8'd0);
              rstate_q <= R_DATA;
            end else begin
              rstate_q <= R_WAIT;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (wait_q == LAT_LAST) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word_s;
            rresp_q  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            rlast_q  <= (rlen_q == 8'd0);
            rstate_q <= R_DATA;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              raddr_q <= raddr_d;
              rdata_q <= rd_word_s;
              rresp_q <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_ram_model.sv
module tb_axi_slave_ram_model;
  localparam int DEPTH = 64;

  logic        CLK, RST;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, PL_WE;
  logic [31:0] WDATA, RDATA, PL_WDATA;
  logic [3:0]  WSTRB;
  logic [5:0]  PL_ADDR;

  // second instance, read latency 4, read channel only
  logic        b_rst, b_arvalid, b_arready, b_rlast, b_rvalid, b_rready, b_pl_we;
  logic        b_awready, b_wready, b_bvalid;
  logic [1:0]  b_bresp, b_rresp;
  logic [15:0] b_araddr;
  logic [31:0] b_rdata, b_pl_wdata;
  logic [5:0]  b_pl_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] got_d [16];
  logic [1:0]  got_r [16];
  logic        got_l [16];

  typedef struct {
    logic [15:0]       addr;
    logic [7:0]        len;
    logic [1:0]        burst;
    logic [3:0][31:0]  d;
    logic [3:0][1:0]   r;
  } rd_vec_t;
  rd_vec_t tbl [8];

  axi_slave_ram_model #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(16), .C_DEPTH(DEPTH), .C_RD_LATENCY(0)) dut (
    .CLK(CLK), .RST(RST), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .PL_WE(PL_WE), .PL_ADDR(PL_ADDR), .PL_WDATA(PL_WDATA));

  axi_slave_ram_model #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(16), .C_DEPTH(DEPTH), .C_RD_LATENCY(4)) dut_lat (
    .CLK(CLK), .RST(b_rst), .AWADDR(16'h0), .AWLEN(8'h0), .AWBURST(2'd1), .AWVALID(1'b0),
    .AWREADY(b_awready), .WDATA(32'h0), .WSTRB(4'h0), .WLAST(1'b0), .WVALID(1'b0), .WREADY(b_wready),
    .BRESP(b_bresp), .BVALID(b_bvalid), .BREADY(1'b0), .ARADDR(b_araddr), .ARLEN(8'd1), .ARBURST(2'd1),
    .ARVALID(b_arvalid), .ARREADY(b_arready), .RDATA(b_rdata), .RRESP(b_rresp), .RLAST(b_rlast),
    .RVALID(b_rvalid), .RREADY(b_rready), .PL_WE(b_pl_we), .PL_ADDR(b_pl_addr), .PL_WDATA(b_pl_wdata));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference next-address rule in plain arithmetic.
  function automatic logic [15:0] m_next(input logic [15:0] a, input logic [7:0] len, input logic [1:0] burst);
    int size, base, na;
    if (burst == 2'd0) return a;
    na = (int'(a) + 4) % 65536;
    if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      size = (int'(len) + 1) * 4;
      base = (int'(a) / size) * size;
      na   = base + ((int'(a) - base + 4) % size);
    end
    return 16'(na);
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    PL_WE = 1'b1; PL_ADDR = 6'(idx); PL_WDATA = d;
    tick();
    PL_WE = 1'b0;
    model_mem[idx] = d;
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           output logic [1:0] resp);
    logic [15:0] a;
    logic err;
    int t, idx;
    resp = 2'd3;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin tick(); t++; end
    check("aw_ready", AWREADY, 1);
    if (!AWREADY) begin AWVALID = 1'b0; return; end
    tick();
    AWVALID = 1'b0;
    a = addr; err = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 3) == 0) tick();
      WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == int'(len)); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin tick(); t++; end
      check("w_ready", WREADY, 1);
      if (!WREADY) begin WVALID = 1'b0; return; end
      tick();
      WVALID = 1'b0;
      idx = int'(a) / 4;
      if (idx < DEPTH) begin
        for (int j = 0; j < 4; j++)
          if (ws[b][j]) model_mem[idx][8*j +: 8] = wd[b][8*j +: 8];
      end else begin
        err = 1'b1;
      end
      a = m_next(a, len, burst);
    end
    WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < 100) begin tick(); t++; end
    check("b_valid", BVALID, 1);
    if (!BVALID) return;
    check("b_resp", BRESP, err ? 2'd2 : 2'd0);
    resp = BRESP;
    for (int s = $urandom_range(0, 2); s > 0; s--) begin
      tick();
      check("b_hold", {BVALID, BRESP}, {1'b1, resp});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("b_done", {BVALID, AWREADY}, 2'b01);
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t;
    logic [34:0] hold;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin tick(); t++; end
    check("ar_ready", ARREADY, 1);
    if (!ARREADY) begin ARVALID = 1'b0; return; end
    tick();
    ARVALID = 1'b0;
    check("r_first_latency", RVALID, 1);
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!RVALID && t < 100) begin tick(); t++; end
      if (!RVALID) begin check("r_valid", RVALID, 1); return; end
      hold = {RDATA, RRESP, RLAST};
      for (int s = $urandom_range(0, 2); s > 0; s--) begin
        tick();
        check("r_hold", {RVALID, RDATA, RRESP, RLAST}, {1'b1, hold});
      end
      got_d[b] = RDATA; got_r[b] = RRESP; got_l[b] = RLAST;
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    check("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  task automatic model_check(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst, input string tag);
    logic [15:0] a;
    logic [31:0] ed;
    logic [1:0]  er;
    int idx;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      idx = int'(a) / 4;
      ed = (idx < DEPTH) ? model_mem[idx] : 32'h0;
      er = (idx < DEPTH) ? 2'd0 : 2'd2;
      check($sformatf("%s beat%0d", tag, b), {got_d[b], got_r[b], got_l[b]}, {ed, er, b == int'(len)});
      a = m_next(a, len, burst);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] a, input logic [7:0] l, input logic [1:0] bu,
                         input logic [31:0] d0, d1, d2, d3, input logic [1:0] r2, r3);
    tbl[i].addr = a; tbl[i].len = l; tbl[i].burst = bu;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2; tbl[i].d[3] = d3;
    tbl[i].r[0] = 2'd0; tbl[i].r[1] = 2'd0; tbl[i].r[2] = r2; tbl[i].r[3] = r3;
  endtask

  initial begin
    logic [1:0] resp;
    logic [15:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    int r;

    // pattern P(i) = C0DE0000 + i preloaded before the table phase
    set_vec(0, 16'h000, 8'd3, 2'd1, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 2'd0, 2'd0);
    set_vec(1, 16'h018, 8'd3, 2'd2, 32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0004, 32'hC0DE0005, 2'd0, 2'd0);
    set_vec(2, 16'h024, 8'd1, 2'd2, 32'hC0DE0009, 32'hC0DE0008, 32'h0, 32'h0, 2'd0, 2'd0);
    set_vec(3, 16'h030, 8'd2, 2'd0, 32'hC0DE000C, 32'hC0DE000C, 32'hC0DE000C, 32'h0, 2'd0, 2'd0);
    set_vec(4, 16'h0F8, 8'd3, 2'd1, 32'hC0DE003E, 32'hC0DE003F, 32'h0, 32'h0, 2'd2, 2'd2);
    set_vec(5, 16'h03C, 8'd2, 2'd2, 32'hC0DE000F, 32'hC0DE0010, 32'hC0DE0011, 32'h0, 2'd0, 2'd0);
    set_vec(6, 16'h044, 8'd3, 2'd3, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013, 32'hC0DE0014, 2'd0, 2'd0);
    set_vec(7, 16'h0FC, 8'd1, 2'd2, 32'hC0DE003F, 32'hC0DE003E, 32'h0, 32'h0, 2'd0, 2'd0);

    RST = 1'b1; b_rst = 1'b1;
    {AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
    {ARADDR, ARLEN, ARBURST, ARVALID, RREADY, PL_WE, PL_ADDR, PL_WDATA} = '0;
    {b_araddr, b_arvalid, b_rready, b_pl_we, b_pl_addr, b_pl_wdata} = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    tick(); tick();
    // preload of the latency instance happens while it is held in reset
    b_pl_we = 1'b1; b_pl_addr = 6'd2; b_pl_wdata = 32'hAAAA5555; tick();
    b_pl_addr = 6'd3; b_pl_wdata = 32'h01020304; tick();
    b_pl_we = 1'b0;
    check("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP, RDATA}, 64'h0);
    RST = 1'b0; b_rst = 1'b0;
    tick();
    check("reset_release", {AWREADY, ARREADY, WREADY, BVALID, RVALID}, 5'b11000);

    // T1 single-beat read, zero latency
    preload(0, 32'h00000093);
    preload(1, 32'h1234ABCD);
    axi_read(16'h0004, 8'd0, 2'd1);
    check("t1_read", {got_d[0], got_r[0], got_l[0]}, {32'h1234ABCD, 2'd0, 1'b1});

    // T2 INCR write then readback
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(16'h0010, 8'd3, 2'd1, resp);
    check("t2_bresp", resp, 2'd0);
    axi_read(16'h0010, 8'd3, 2'd1);
    for (int b = 0; b < 4; b++)
      check($sformatf("t2_beat%0d", b), {got_d[b], got_r[b], got_l[b]}, {32'(b + 1), 2'd0, b == 3});

    // T3 WRAP read
    preload(4, 32'hA); preload(5, 32'hB); preload(6, 32'hC); preload(7, 32'hD);
    axi_read(16'h0018, 8'd3, 2'd2);
    check("t3_wrap", {got_d[0], got_d[1], got_d[2], got_d[3]}, {32'hC, 32'hD, 32'hA, 32'hB});

    // T4 byte strobe and FIXED write
    preload(8, 32'h11223344);
    preload(10, 32'h5A5A5A5A);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h2;
    axi_write(16'h0020, 8'd0, 2'd1, resp);
    axi_read(16'h0020, 8'd0, 2'd1);
    check("t4_strobe", got_d[0], 32'h1122FF44);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(16'h0024, 8'd1, 2'd0, resp);
    axi_read(16'h0024, 8'd1, 2'd1);
    check("t4_fixed", {got_d[0], got_d[1]}, {32'h22222222, 32'h5A5A5A5A});

    // T5 out-of-range
    axi_read(16'h0100, 8'd1, 2'd1);
    check("t5_oor_read", {got_d[0], got_r[0], got_l[0], got_d[1], got_r[1], got_l[1]},
          {32'h0, 2'd2, 1'b0, 32'h0, 2'd2, 1'b1});
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(16'h0100, 8'd0, 2'd1, resp);
    check("t5_oor_bresp", resp, 2'd2);
    axi_read(16'h0000, 8'd0, 2'd1);
    check("t5_no_alias", got_d[0], 32'h00000093);

    // preload accepted while in reset
    RST = 1'b1;
    preload(20, 32'hCAFEF00D);
    RST = 1'b0;
    tick();
    axi_read(16'h0050, 8'd0, 2'd1);
    check("preload_in_reset", got_d[0], 32'hCAFEF00D);

    // T6 latency 4, stalled RREADY, reset mid-burst
    b_araddr = 16'h0008; b_arvalid = 1'b1;
    check("lat_arready", b_arready, 1);
    tick();
    b_arvalid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("lat_cycle%0d", c), b_rvalid, c == 5);
      if (c < 5) tick();
    end
    for (int s = 0; s < 3; s++) begin
      check("lat_hold", {b_rvalid, b_rdata, b_rresp, b_rlast}, {1'b1, 32'hAAAA5555, 2'd0, 1'b0});
      tick();
    end
    b_rready = 1'b1; tick(); b_rready = 1'b0;
    check("lat_beat1", {b_rvalid, b_rdata, b_rlast}, {1'b1, 32'h01020304, 1'b1});
    b_rst = 1'b1; tick();
    check("lat_abort", {b_rvalid, b_arready}, 2'b00);
    b_rst = 1'b0; tick();
    check("lat_recover", {b_rvalid, b_arready}, 2'b01);

    // table-driven reads over a known pattern
    for (int i = 0; i < DEPTH; i++) preload(i, 32'hC0DE0000 + 32'(i));
    for (int v = 0; v < 8; v++) begin
      axi_read(tbl[v].addr, tbl[v].len, tbl[v].burst);
      for (int b = 0; b <= int'(tbl[v].len); b++)
        check($sformatf("tbl%0d_beat%0d", v, b), {got_d[b], got_r[b], got_l[b]},
              {tbl[v].d[b], tbl[v].r[b], b == int'(tbl[v].len)});
    end

    // randomized write/read traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      r  = $urandom_range(0, 8);
      rl = (r == 8) ? 8'd15 : 8'(r);
      ra = 16'($urandom_range(0, 16'h11F));
      rb = 2'($urandom_range(0, 3));
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15)); end
      axi_write(ra, rl, rb, resp);
      axi_read(ra, rl, rb);
      model_check(ra, rl, rb, $sformatf("rnd%0d_rb", it));
      r  = $urandom_range(0, 8);
      rl = (r == 8) ? 8'd15 : 8'(r);
      ra = 16'($urandom_range(0, 16'h11F));
      rb = 2'($urandom_range(0, 3));
      axi_read(ra, rl, rb);
      model_check(ra, rl, rb, $sformatf("rnd%0d_rd", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
